// File: rtl/lsu_hazard_scoreboard_if.sv
// Control-flow classification of the D-stage instruction plus the
// scoreboard's handshake bundle. master = pipeline side (drives issue/wb/D
// fields), slave = scoreboard (drives hazard outputs and status).
package lsu_hazard_scoreboard_pkg;
  typedef enum logic [1:0] {
    CFLOW_NONE   = 2'd0,
    CFLOW_BRANCH = 2'd1,
    CFLOW_JALR   = 2'd2,
    CFLOW_JAL    = 2'd3
  } cflow_mode_t;
endpackage

interface lsu_hazard_scoreboard_if #(
  parameter int NREG            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
  import lsu_hazard_scoreboard_pkg::*;
  localparam int RW = $clog2(NREG);

  // E-stage issue and writeback of long-latency ops
  logic              issue_valid_e;
  logic [RW-1:0]     issue_rd_e;
  logic              wb_valid;
  logic [RW-1:0]     wb_rd;
  // D-stage instruction fields
  logic [RW-1:0]     rs1_d;
  logic [RW-1:0]     rs2_d;
  logic [RW-1:0]     rd_d;
  logic              use_rs1_d;
  logic              use_rs2_d;
  logic              wr_rd_d;
  logic              long_d;
  cflow_mode_t       cflow_mode;
  // hazard outputs and status
  logic              flag;
  logic              stall_f;
  logic              stall_d;
  logic              flush_e;
  logic [CNT_W-1:0]  outstanding;
  logic              sb_error;

  modport master (
    output issue_valid_e, issue_rd_e, wb_valid, wb_rd,
           rs1_d, rs2_d, rd_d, use_rs1_d, use_rs2_d, wr_rd_d, long_d, cflow_mode,
    input  flag, stall_f, stall_d, flush_e, outstanding, sb_error
  );

  modport slave (
    input  issue_valid_e, issue_rd_e, wb_valid, wb_rd,
           rs1_d, rs2_d, rd_d, use_rs1_d, use_rs2_d, wr_rd_d, long_d, cflow_mode,
    output flag, stall_f, stall_d, flush_e, outstanding, sb_error
  );
endinterface

// File: rtl/lsu_hazard_scoreboard.sv
// Per-register pending scoreboard for unbounded-latency loads and mul/div;
// stall outputs are combinational off registered state (0 cycles), counter
// and error flag update on the clock. Ports: clk, reset, sb (slave modport).
module lsu_hazard_scoreboard
  import lsu_hazard_scoreboard_pkg::*;
#(
  parameter int NREG            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  lsu_hazard_scoreboard_if.slave  sb
);

  logic [NREG-1:1]  pending_q;
  logic [CNT_W-1:0] outstanding_q;
  logic             sb_error_q;

  logic [NREG-1:0]  pend_full;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  clr_vec;
  logic [NREG-1:0]  busy_vec;
  logic [NREG-1:0]  busy_br_vec;
  logic [NREG-1:0]  rs_busy_vec;
  logic [CNT_W:0]   proj_cnt;
  logic             use_br;
  logic             raw, waw, full, stall;
  logic             overflow, underflow, stray_wb;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (sb.issue_valid_e) set_vec[sb.issue_rd_e] = 1'b1;
    if (sb.wb_valid)      clr_vec[sb.wb_rd]      = 1'b1;
    // x0 is never tracked
    set_vec[0] = 1'b0;
    clr_vec[0] = 1'b0;
    pend_full  = {pending_q, 1'b0};

    // Set beats clear, so busy_vec is also exactly the next pending state.
    busy_vec    = (pend_full & ~clr_vec) | set_vec;
    // D-stage comparators cannot take a same-cycle writeback bypass.
    busy_br_vec = pend_full | set_vec;

    use_br      = (sb.cflow_mode == CFLOW_BRANCH) || (sb.cflow_mode == CFLOW_JALR);
    rs_busy_vec = use_br ? busy_br_vec : busy_vec;

    raw = (sb.use_rs1_d && rs_busy_vec[sb.rs1_d]) ||
          (sb.use_rs2_d && rs_busy_vec[sb.rs2_d]);
    waw = sb.wr_rd_d && (sb.rd_d != '0) && busy_vec[sb.rd_d];

    // Projected in-flight count; an underflowing writeback projects to 0,
    // which can never reach the limit, same as the signed arithmetic would.
    proj_cnt = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, sb.issue_valid_e};
    if (sb.wb_valid && (proj_cnt != '0)) proj_cnt = proj_cnt - (CNT_W+1)'(1);
    full = sb.long_d && (proj_cnt >= (CNT_W+1)'(MAX_OUTSTANDING));

    stall = raw | waw | full;

    overflow  = sb.issue_valid_e && !sb.wb_valid &&
                (outstanding_q == CNT_W'(MAX_OUTSTANDING));
    underflow = sb.wb_valid && !sb.issue_valid_e && (outstanding_q == '0);
    stray_wb  = sb.wb_valid && (sb.wb_rd != '0) && !pend_full[sb.wb_rd] &&
                !(sb.issue_valid_e && (sb.issue_rd_e == sb.wb_rd));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      sb_error_q    <= 1'b0;
    end else begin
      pending_q <= busy_vec[NREG-1:1];
      // Counter saturates at both ends; the error flag records the attempt.
      case ({sb.issue_valid_e, sb.wb_valid})
        2'b10: if (!overflow)  outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01: if (!underflow) outstanding_q <= outstanding_q - CNT_W'(1);
        default: ;
      endcase
      if (overflow || underflow || stray_wb) sb_error_q <= 1'b1;
    end
  end

  assign sb.flag        = stall;
  assign sb.stall_f     = stall;
  assign sb.stall_d     = stall;
  assign sb.flush_e     = stall;
  assign sb.outstanding = outstanding_q;
  assign sb.sb_error    = sb_error_q;

endmodule

// File: tb/tb_lsu_hazard_scoreboard.sv
module tb_lsu_hazard_scoreboard;
  import lsu_hazard_scoreboard_pkg::*;

  localparam int NREG  = 32;
  localparam int MAXO  = 4;
  localparam int CNT_W = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // reference model state
  bit   m_pend [NREG];
  int   m_cnt;
  bit   m_err;

  lsu_hazard_scoreboard_if #(.NREG(NREG), .MAX_OUTSTANDING(MAXO)) bus ();

  lsu_hazard_scoreboard #(.NREG(NREG), .MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.issue_valid_e = 0; bus.issue_rd_e = '0;
    bus.wb_valid = 0;      bus.wb_rd = '0;
    bus.rs1_d = '0; bus.rs2_d = '0; bus.rd_d = '0;
    bus.use_rs1_d = 0; bus.use_rs2_d = 0; bus.wr_rd_d = 0;
    bus.long_d = 0; bus.cflow_mode = CFLOW_NONE;
  endtask

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) m_pend[i] = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // Is register r considered in flight for a D-stage reader?
  function automatic bit m_busy(int r, bit branch_cmp);
    if (r == 0) return 0;
    if (bus.issue_valid_e && int'(bus.issue_rd_e) == r) return 1;
    if (branch_cmp) return m_pend[r];
    return m_pend[r] && !(bus.wb_valid && int'(bus.wb_rd) == r);
  endfunction

  function automatic bit m_stall();
    bit br, raw, waw, full;
    br   = (bus.cflow_mode == CFLOW_BRANCH) || (bus.cflow_mode == CFLOW_JALR);
    raw  = (bus.use_rs1_d && m_busy(int'(bus.rs1_d), br)) ||
           (bus.use_rs2_d && m_busy(int'(bus.rs2_d), br));
    waw  = bus.wr_rd_d && m_busy(int'(bus.rd_d), 0);
    full = bus.long_d &&
           (m_cnt + int'(bus.issue_valid_e) - int'(bus.wb_valid) >= MAXO);
    return raw | waw | full;
  endfunction

  task automatic m_update();
    int n;
    if (bus.wb_valid && bus.wb_rd != 0) begin
      if (!m_pend[bus.wb_rd] && !(bus.issue_valid_e && bus.issue_rd_e == bus.wb_rd))
        m_err = 1;
      m_pend[bus.wb_rd] = 0;
    end
    if (bus.issue_valid_e && bus.issue_rd_e != 0) m_pend[bus.issue_rd_e] = 1;
    n = m_cnt + int'(bus.issue_valid_e) - int'(bus.wb_valid);
    if (n < 0)    begin n = 0;    m_err = 1; end
    if (n > MAXO) begin n = MAXO; m_err = 1; end
    m_cnt = n;
  endtask

  // Advance one clock and keep the model in step with the DUT.
  task automatic tick();
    @(posedge clk);
    if (reset) m_clear(); else m_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    m_clear();
    @(negedge clk);
    bus.use_rs1_d = 1; bus.rs1_d = 5;
    #1;
    total++; if (bus.outstanding !== '0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", bus.outstanding); end
    total++; if (bus.sb_error !== 1'b0) begin bad++; $display("FAIL reset_sb_error got=%b want=0", bus.sb_error); end
    total++; if (bus.flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", bus.flag); end
    tick();
    @(negedge clk);
    reset = 0;
    idle();
  endtask

  task automatic test_raw_alu();
    @(negedge clk);
    idle();
    bus.issue_valid_e = 1; bus.issue_rd_e = 5;
    bus.use_rs1_d = 1; bus.rs1_d = 5;
    #1;
    total++; if (bus.stall_d !== 1'b1) begin bad++; $display("FAIL raw_alu_issue_cycle got=%b want=1", bus.stall_d); end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.issue_valid_e = 0;
      #1;
      total++; if (bus.stall_d !== 1'b1 || bus.outstanding !== 3'd1) begin
        bad++; $display("FAIL raw_alu_wait stall=%b out=%0d want stall=1 out=1", bus.stall_d, bus.outstanding);
      end
      tick();
    end
    @(negedge clk);
    bus.wb_valid = 1; bus.wb_rd = 5;
    #1;
    total++; if (bus.stall_d !== 1'b0) begin bad++; $display("FAIL raw_alu_wb_cycle got=%b want=0", bus.stall_d); end
    tick();
    total++; if (bus.outstanding !== 3'd0 || bus.sb_error !== 1'b0) begin
      bad++; $display("FAIL raw_alu_drain out=%0d err=%b want out=0 err=0", bus.outstanding, bus.sb_error);
    end
  endtask

  task automatic test_raw_branch();
    @(negedge clk);
    idle();
    bus.issue_valid_e = 1; bus.issue_rd_e = 5;
    tick();
    @(negedge clk);
    idle();
    bus.cflow_mode = CFLOW_BRANCH; bus.use_rs1_d = 1; bus.rs1_d = 5;
    #1;
    total++; if (bus.stall_f !== 1'b1) begin bad++; $display("FAIL br_wait got=%b want=1", bus.stall_f); end
    tick();
    @(negedge clk);
    bus.wb_valid = 1; bus.wb_rd = 5;
    #1;
    total++; if (bus.stall_f !== 1'b1) begin bad++; $display("FAIL br_wb_cycle got=%b want=1", bus.stall_f); end
    tick();
    @(negedge clk);
    bus.wb_valid = 0;
    #1;
    total++; if (bus.stall_f !== 1'b0 || bus.outstanding !== 3'd0) begin
      bad++; $display("FAIL br_after_wb stall=%b out=%0d want stall=0 out=0", bus.stall_f, bus.outstanding);
    end
    tick();
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      idle();
      bus.issue_valid_e = 1; bus.issue_rd_e = 5'(r);
      tick();
    end
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.outstanding !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", bus.outstanding); end
    bus.long_d = 1; bus.wr_rd_d = 1; bus.rd_d = 6;
    #1;
    total++; if (bus.flush_e !== 1'b1) begin bad++; $display("FAIL full_stall got=%b want=1", bus.flush_e); end
    bus.wb_valid = 1; bus.wb_rd = 1;
    #1;
    total++; if (bus.flush_e !== 1'b0) begin bad++; $display("FAIL full_with_wb got=%b want=0", bus.flush_e); end
    tick();
    total++; if (bus.outstanding !== 3'd3) begin bad++; $display("FAIL full_after_wb got=%0d want=3", bus.outstanding); end
    for (int r = 2; r <= 4; r++) begin
      @(negedge clk);
      idle();
      bus.wb_valid = 1; bus.wb_rd = 5'(r);
      tick();
    end
    total++; if (bus.outstanding !== 3'd0 || bus.sb_error !== 1'b0) begin
      bad++; $display("FAIL full_drain out=%0d err=%b want out=0 err=0", bus.outstanding, bus.sb_error);
    end
  endtask

  task automatic test_waw();
    @(negedge clk);
    idle();
    bus.issue_valid_e = 1; bus.issue_rd_e = 7;
    tick();
    @(negedge clk);
    idle();
    bus.wr_rd_d = 1; bus.rd_d = 7;
    #1;
    total++; if (bus.stall_d !== 1'b1) begin bad++; $display("FAIL waw_rd7 got=%b want=1", bus.stall_d); end
    bus.rd_d = 0;
    #1;
    total++; if (bus.stall_d !== 1'b0) begin bad++; $display("FAIL waw_rd0 got=%b want=0", bus.stall_d); end
    tick();
    @(negedge clk);
    idle();
    bus.wb_valid = 1; bus.wb_rd = 7;
    tick();
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    idle();
    bus.issue_valid_e = 1; bus.issue_rd_e = 9;
    tick();
    @(negedge clk);
    bus.wb_valid = 1; bus.wb_rd = 9;
    tick();
    total++; if (bus.outstanding !== 3'd1 || bus.sb_error !== 1'b0) begin
      bad++; $display("FAIL same_cycle out=%0d err=%b want out=1 err=0", bus.outstanding, bus.sb_error);
    end
    @(negedge clk);
    idle();
    bus.use_rs2_d = 1; bus.rs2_d = 9;
    #1;
    total++; if (bus.stall_d !== 1'b1) begin bad++; $display("FAIL same_cycle_pending got=%b want=1", bus.stall_d); end
    bus.wb_valid = 1; bus.wb_rd = 9;
    tick();
    total++; if (bus.outstanding !== 3'd0) begin bad++; $display("FAIL same_cycle_drain got=%0d want=0", bus.outstanding); end
  endtask

  task automatic test_error_and_reset();
    @(negedge clk);
    idle();
    bus.wb_valid = 1; bus.wb_rd = 12;
    tick();
    total++; if (bus.sb_error !== 1'b1 || bus.outstanding !== 3'd0) begin
      bad++; $display("FAIL stray_wb err=%b out=%0d want err=1 out=0", bus.sb_error, bus.outstanding);
    end
    for (int r = 3; r <= 5; r++) begin
      @(negedge clk);
      idle();
      bus.issue_valid_e = 1; bus.issue_rd_e = 5'(r);
      tick();
    end
    total++; if (bus.sb_error !== 1'b1 || bus.outstanding !== 3'd3) begin
      bad++; $display("FAIL err_sticky err=%b out=%0d want err=1 out=3", bus.sb_error, bus.outstanding);
    end
    @(negedge clk);
    idle();
    bus.use_rs1_d = 1; bus.rs1_d = 3;
    #1;
    total++; if (bus.stall_d !== 1'b1) begin bad++; $display("FAIL pre_reset_stall got=%b want=1", bus.stall_d); end
    reset = 1;
    #1;
    total++; if (bus.outstanding !== '0 || bus.sb_error !== 1'b0) begin
      bad++; $display("FAIL mid_reset_state out=%0d err=%b want 0 0", bus.outstanding, bus.sb_error);
    end
    total++; if ({bus.flag, bus.stall_f, bus.stall_d, bus.flush_e} !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_stalls got=%b want=0000", {bus.flag, bus.stall_f, bus.stall_d, bus.flush_e});
    end
    m_clear();
    tick();
    @(negedge clk);
    reset = 0;
    idle();
  endtask

  task automatic test_random();
    int start, r;
    bit found;
    bit s;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      idle();
      bus.issue_valid_e = ($urandom_range(0, 2) == 0);
      bus.issue_rd_e    = 5'($urandom_range(0, 7));
      if (m_cnt > 0 && $urandom_range(0, 2) == 0) begin
        bus.wb_valid = 1;
        found = 0;
        start = $urandom_range(1, 7);
        for (int k = 0; k < 7; k++) begin
          r = 1 + (start - 1 + k) % 7;
          if (!found && m_pend[r]) begin bus.wb_rd = 5'(r); found = 1; end
        end
        if (!found) bus.wb_rd = 0;
      end else if ($urandom_range(0, 49) == 0) begin
        bus.wb_valid = 1; bus.wb_rd = 5'($urandom_range(0, 31));
      end
      bus.rs1_d = 5'($urandom_range(0, 7));
      bus.rs2_d = 5'($urandom_range(0, 7));
      bus.rd_d  = 5'($urandom_range(0, 7));
      bus.use_rs1_d = 1'($urandom_range(0, 1));
      bus.use_rs2_d = 1'($urandom_range(0, 1));
      bus.wr_rd_d   = 1'($urandom_range(0, 1));
      bus.long_d    = 1'($urandom_range(0, 1));
      bus.cflow_mode = cflow_mode_t'($urandom_range(0, 3));
      #1;
      s = m_stall();
      total++; if ({bus.flag, bus.stall_f, bus.stall_d, bus.flush_e} !== {4{s}}) begin
        bad++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", c, {bus.flag, bus.stall_f, bus.stall_d, bus.flush_e}, {4{s}});
      end
      tick();
      total++; if (bus.outstanding !== CNT_W'(m_cnt) || bus.sb_error !== m_err) begin
        bad++; $display("FAIL rnd_state cyc=%0d out=%0d err=%b want out=%0d err=%b", c, bus.outstanding, bus.sb_error, m_cnt, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw_alu();
    test_raw_branch();
    test_full();
    test_waw();
    test_same_cycle();
    test_error_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
